// File: rtl/fwd_arb_rr.sv
// fwd_arb_rr: round-robin forwarding arbiter between N packetfilter cores and one forwarder.
//   clk, rst (async, active-low)
//   forwarder side: addr, rd_en, done, ack in; rd_data, rd_data_vld, byte_len, rdy out
//   core side: core_en, fwd_rd_data, fwd_rd_data_vld, fwd_byte_len, rdy_for_fwd in;
//              fwd_addr, fwd_rd_en, fwd_done, rdy_for_fwd_ack out
//   status: sel_idx (current/last granted core), busy (grant held)
module fwd_arb_rr #(
    parameter int N                 = 4,
    parameter int SN_FWD_ADDR_WIDTH = 8,
    parameter int SN_FWD_DATA_WIDTH = 64,
    parameter int PLEN_WIDTH        = 32,
    parameter int MUX_LAT           = 0,
    localparam int IDX_W            = (N > 1) ? $clog2(N) : 1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [SN_FWD_ADDR_WIDTH-1:0]   addr,
    input  logic                           rd_en,
    output logic [SN_FWD_DATA_WIDTH-1:0]   rd_data,
    output logic                           rd_data_vld,
    output logic [PLEN_WIDTH-1:0]          byte_len,
    input  logic                           done,
    output logic                           rdy,
    input  logic                           ack,
    input  logic [N-1:0]                   core_en,
    output logic [SN_FWD_ADDR_WIDTH-1:0]   fwd_addr,
    output logic [N-1:0]                   fwd_rd_en,
    input  logic [N*SN_FWD_DATA_WIDTH-1:0] fwd_rd_data,
    input  logic [N-1:0]                   fwd_rd_data_vld,
    input  logic [N*PLEN_WIDTH-1:0]        fwd_byte_len,
    output logic [N-1:0]                   fwd_done,
    input  logic [N-1:0]                   rdy_for_fwd,
    output logic [N-1:0]                   rdy_for_fwd_ack,
    output logic [IDX_W-1:0]               sel_idx,
    output logic                           busy
);
    localparam int W = SN_FWD_DATA_WIDTH;
    localparam int L = PLEN_WIDTH;

    typedef enum logic {IDLE, BUSY} state_t;

    state_t                r_state, w_next;
    logic [IDX_W-1:0]      r_sel, r_last;
    logic [N-1:0]          w_elig, w_sel_oh, w_cand_oh;
    logic [IDX_W-1:0]      w_hi, w_lo, w_cand;
    logic                  w_hi_found, w_grant;
    logic [W-1:0]          w_d0;
    logic [L-1:0]          w_l0;
    logic                  w_v0;

    assign w_elig  = rdy_for_fwd & core_en;
    assign w_grant = rdy && ack;

    // Rotating search: lowest eligible index above last_grant, else wrap to lowest eligible.
    // The loop runs high-to-low so the final assignment is the lowest qualifying index.
    always_comb begin
        w_hi       = '0;
        w_lo       = '0;
        w_hi_found = 1'b0;
        w_sel_oh   = '0;
        w_d0       = '0;
        w_l0       = '0;
        w_v0       = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (w_elig[i] && IDX_W'(i) > r_last) begin
                w_hi       = IDX_W'(i);
                w_hi_found = 1'b1;
            end
            if (w_elig[i])
                w_lo = IDX_W'(i);
            if (IDX_W'(i) == r_sel) begin
                w_sel_oh[i] = 1'b1;
                w_d0        = fwd_rd_data[i*W +: W];
                w_l0        = fwd_byte_len[i*L +: L];
                w_v0        = fwd_rd_data_vld[i];
            end
        end
        w_cand = w_hi_found ? w_hi : w_lo;
        for (int i = 0; i < N; i++)
            w_cand_oh[i] = IDX_W'(i) == w_cand;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
            r_sel   <= '0;
            r_last  <= IDX_W'(N - 1);
        end else begin
            r_state <= w_next;
            if (r_state == IDLE && w_grant)
                r_sel <= w_cand;
            if (r_state == BUSY && done)
                r_last <= r_sel;
        end
    end

    always_comb begin
        w_next = r_state;
        if (r_state == IDLE && w_grant)
            w_next = BUSY;
        else if (r_state == BUSY && done)
            w_next = IDLE;
    end

    // rst gates rdy directly so no ack escapes while reset is held with cores ready.
    always_comb begin
        busy            = r_state == BUSY;
        rdy             = rst && r_state == IDLE && |w_elig;
        rdy_for_fwd_ack = (rdy && ack) ? w_cand_oh : '0;
        fwd_rd_en       = (busy && rd_en) ? w_sel_oh : '0;
        fwd_done        = (busy && done) ? w_sel_oh : '0;
        fwd_addr        = addr;
        sel_idx         = r_sel;
    end

    generate
        if (MUX_LAT == 0) begin : g_comb
            assign rd_data     = w_d0;
            assign byte_len    = w_l0;
            assign rd_data_vld = w_v0 && busy;
        end else begin : g_pipe
            logic [W-1:0] r_d [MUX_LAT];
            logic [L-1:0] r_l [MUX_LAT];
            logic         r_v [MUX_LAT];
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    r_d <= '{default: '0};
                    r_l <= '{default: '0};
                    r_v <= '{default: 1'b0};
                end else begin
                    r_d[0] <= w_d0;
                    r_l[0] <= w_l0;
                    r_v[0] <= w_v0 && busy;
                    for (int s = 1; s < MUX_LAT; s++) begin
                        r_d[s] <= r_d[s-1];
                        r_l[s] <= r_l[s-1];
                        r_v[s] <= r_v[s-1];
                    end
                end
            end
            assign rd_data     = r_d[MUX_LAT-1];
            assign byte_len    = r_l[MUX_LAT-1];
            assign rd_data_vld = r_v[MUX_LAT-1];
        end
    endgenerate
endmodule

// File: tb/tb_fwd_arb_rr.sv
// tb_fwd_arb_rr: directed bench driving a combinational (MUX_LAT=0) and a pipelined (MUX_LAT=2) arbiter in parallel.
module tb_fwd_arb_rr;
    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [7:0]   addr = '0;
    logic         rd_en = 1'b0, done = 1'b0, ack = 1'b0;
    logic [3:0]   core_en = '0, rfd = '0, fvld = '0;
    logic [255:0] fdata = '0;
    logic [127:0] flen = '0;

    logic [63:0]  rd_data0, rd_data2;
    logic [31:0]  byte_len0, byte_len2;
    logic         vld0, vld2, rdy0, rdy2, busy0, busy2;
    logic [7:0]   fwd_addr0, fwd_addr2;
    logic [3:0]   fwd_rd_en0, fwd_rd_en2, fwd_done0, fwd_done2, ack0, ack2;
    logic [1:0]   sel0, sel2;

    int ncmp = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    fwd_arb_rr #(.N(4), .MUX_LAT(0)) u0 (
        .clk(clk), .rst(rst), .addr(addr), .rd_en(rd_en), .rd_data(rd_data0),
        .rd_data_vld(vld0), .byte_len(byte_len0), .done(done), .rdy(rdy0), .ack(ack),
        .core_en(core_en), .fwd_addr(fwd_addr0), .fwd_rd_en(fwd_rd_en0),
        .fwd_rd_data(fdata), .fwd_rd_data_vld(fvld), .fwd_byte_len(flen),
        .fwd_done(fwd_done0), .rdy_for_fwd(rfd), .rdy_for_fwd_ack(ack0),
        .sel_idx(sel0), .busy(busy0)
    );

    fwd_arb_rr #(.N(4), .MUX_LAT(2)) u2 (
        .clk(clk), .rst(rst), .addr(addr), .rd_en(rd_en), .rd_data(rd_data2),
        .rd_data_vld(vld2), .byte_len(byte_len2), .done(done), .rdy(rdy2), .ack(ack),
        .core_en(core_en), .fwd_addr(fwd_addr2), .fwd_rd_en(fwd_rd_en2),
        .fwd_rd_data(fdata), .fwd_rd_data_vld(fvld), .fwd_byte_len(flen),
        .fwd_done(fwd_done2), .rdy_for_fwd(rfd), .rdy_for_fwd_ack(ack2),
        .sel_idx(sel2), .busy(busy2)
    );

    task automatic reset_dut();
        @(negedge clk);
        rst = 1'b0; addr = '0; rd_en = 1'b0; done = 1'b0; ack = 1'b0;
        core_en = '0; rfd = '0; fvld = '0; fdata = '0; flen = '0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b0; core_en = 4'hF; rfd = 4'hF; ack = 1'b1;
        #1;
        ncmp++; if (rdy0 !== 1'b0) begin nerr++; $display("FAIL rst_rdy got %b want 0", rdy0); end
        ncmp++; if (ack0 !== 4'b0000) begin nerr++; $display("FAIL rst_ack got %b want 0000", ack0); end
        ncmp++; if (busy0 !== 1'b0) begin nerr++; $display("FAIL rst_busy got %b want 0", busy0); end
        ncmp++; if (sel0 !== 2'd0) begin nerr++; $display("FAIL rst_sel got %0d want 0", sel0); end
        ncmp++; if (vld0 !== 1'b0 || vld2 !== 1'b0) begin nerr++; $display("FAIL rst_vld got %b/%b want 0/0", vld0, vld2); end
        ncmp++; if (rd_data2 !== 64'd0 || byte_len2 !== 32'd0) begin nerr++; $display("FAIL rst_pipe got %h/%h want 0/0", rd_data2, byte_len2); end
        @(posedge clk); #1;
        ncmp++; if (busy0 !== 1'b0 || ack0 !== 4'b0000) begin nerr++; $display("FAIL rst_hold got busy=%b ack=%b want 0/0000", busy0, ack0); end
        @(negedge clk);
        rst = 1'b1; ack = 1'b0; rfd = '0;
    endtask

    task automatic test_first_grant();
        reset_dut();
        @(negedge clk);
        core_en = 4'hF; rfd = 4'b1010; ack = 1'b1; addr = 8'h5A;
        #1;
        ncmp++; if (rdy0 !== 1'b1) begin nerr++; $display("FAIL fg_rdy got %b want 1", rdy0); end
        ncmp++; if (ack0 !== 4'b0010) begin nerr++; $display("FAIL fg_ack got %b want 0010", ack0); end
        ncmp++; if (fwd_addr0 !== 8'h5A) begin nerr++; $display("FAIL fg_addr got %h want 5a", fwd_addr0); end
        @(negedge clk);
        ack = 1'b0;
        #1;
        ncmp++; if (busy0 !== 1'b1 || busy2 !== 1'b1) begin nerr++; $display("FAIL fg_busy got %b/%b want 1/1", busy0, busy2); end
        ncmp++; if (sel0 !== 2'd1) begin nerr++; $display("FAIL fg_sel got %0d want 1", sel0); end
        ncmp++; if (rdy0 !== 1'b0 || ack0 !== 4'b0000) begin nerr++; $display("FAIL fg_busy_rdy got rdy=%b ack=%b want 0/0000", rdy0, ack0); end
        @(negedge clk); done = 1'b1;
        @(negedge clk); done = 1'b0;
    endtask

    task automatic test_rotation();
        int seq [5] = '{0, 1, 2, 3, 0};
        logic [3:0] e;
        reset_dut();
        core_en = 4'hF; rfd = 4'hF;
        for (int k = 0; k < 5; k++) begin
            e = 4'b0001 << seq[k];
            @(negedge clk);
            done = 1'b0; ack = 1'b1;
            #1;
            ncmp++; if (ack0 !== e) begin nerr++; $display("FAIL rot_ack[%0d] got %b want %b", k, ack0, e); end
            @(negedge clk);
            done = 1'b1;
            #1;
            ncmp++; if (sel0 !== seq[k] || busy0 !== 1'b1) begin nerr++; $display("FAIL rot_sel[%0d] got sel=%0d busy=%b want %0d/1", k, sel0, busy0, seq[k]); end
            ncmp++; if (ack0 !== 4'b0000) begin nerr++; $display("FAIL rot_ack_done[%0d] got %b want 0000", k, ack0); end
        end
        @(negedge clk);
        done = 1'b0; ack = 1'b0;
        #1;
        ncmp++; if (busy0 !== 1'b0 || rdy0 !== 1'b1) begin nerr++; $display("FAIL rot_end got busy=%b rdy=%b want 0/1", busy0, rdy0); end
    endtask

    task automatic test_mask();
        int seq [4] = '{0, 1, 3, 0};
        logic [3:0] e;
        reset_dut();
        core_en = 4'b1011; rfd = 4'hF;
        for (int k = 0; k < 4; k++) begin
            e = 4'b0001 << seq[k];
            @(negedge clk);
            done = 1'b0; ack = 1'b1;
            #1;
            ncmp++; if (ack0 !== e) begin nerr++; $display("FAIL mask_ack[%0d] got %b want %b", k, ack0, e); end
            @(negedge clk);
            ack = 1'b0; done = 1'b1;
            #1;
            ncmp++; if (sel0 !== seq[k]) begin nerr++; $display("FAIL mask_sel[%0d] got %0d want %0d", k, sel0, seq[k]); end
        end
        @(negedge clk);
        done = 1'b0; rfd = 4'b0100; ack = 1'b1;
        #1;
        ncmp++; if (rdy0 !== 1'b0 || ack0 !== 4'b0000) begin nerr++; $display("FAIL mask_only2 got rdy=%b ack=%b want 0/0000", rdy0, ack0); end
        @(negedge clk);
        ack = 1'b0;
        #1;
        ncmp++; if (busy0 !== 1'b0) begin nerr++; $display("FAIL mask_idle got busy=%b want 0", busy0); end
    endtask

    task automatic test_core3();
        reset_dut();
        @(negedge clk);
        core_en = 4'hF; rfd = 4'b1000; rd_en = 1'b1; done = 1'b1;
        #1;
        ncmp++; if (fwd_rd_en0 !== 4'b0000 || fwd_done0 !== 4'b0000) begin nerr++; $display("FAIL idle_gate got rd_en=%b done=%b want 0000/0000", fwd_rd_en0, fwd_done0); end
        @(negedge clk);
        rd_en = 1'b0; done = 1'b0; ack = 1'b1;
        #1;
        ncmp++; if (ack0 !== 4'b1000) begin nerr++; $display("FAIL c3_ack got %b want 1000", ack0); end
        @(negedge clk);
        ack = 1'b0; core_en = '0; rfd = '0; rd_en = 1'b1;
        #1;
        ncmp++; if (fwd_rd_en0 !== 4'b1000 || fwd_done0 !== 4'b0000) begin nerr++; $display("FAIL c3_rd got rd_en=%b done=%b want 1000/0000", fwd_rd_en0, fwd_done0); end
        @(negedge clk);
        #1;
        ncmp++; if (busy0 !== 1'b1) begin nerr++; $display("FAIL c3_persist got busy=%b want 1", busy0); end
        done = 1'b1;
        #1;
        ncmp++; if (fwd_done0 !== 4'b1000 || fwd_rd_en0 !== 4'b1000) begin nerr++; $display("FAIL c3_done got done=%b rd_en=%b want 1000/1000", fwd_done0, fwd_rd_en0); end
        @(negedge clk);
        done = 1'b0; rd_en = 1'b0; core_en = 4'hF; rfd = 4'hF; ack = 1'b1;
        #1;
        ncmp++; if (ack0 !== 4'b0001) begin nerr++; $display("FAIL c3_next got %b want 0001", ack0); end
        @(negedge clk); ack = 1'b0; done = 1'b1;
        @(negedge clk); done = 1'b0;
    endtask

    task automatic test_return_path();
        reset_dut();
        @(negedge clk);
        core_en = 4'hF; rfd = 4'b0010; ack = 1'b1;
        @(negedge clk);
        ack = 1'b0; rfd = '0;
        fdata[63:0] = 64'h1111; flen[31:0] = 32'd7; fvld = 4'b0001;
        #1;
        ncmp++; if (vld0 !== 1'b0) begin nerr++; $display("FAIL ret_other0 got %b want 0", vld0); end
        @(negedge clk);
        fdata[127:64] = 64'hDEAD_BEEF; flen[63:32] = 32'd1500; fvld = 4'b0010;
        #1;
        ncmp++; if (vld0 !== 1'b1 || rd_data0 !== 64'hDEAD_BEEF || byte_len0 !== 32'd1500) begin nerr++; $display("FAIL ret_comb got vld=%b d=%h l=%0d want 1/deadbeef/1500", vld0, rd_data0, byte_len0); end
        ncmp++; if (vld2 !== 1'b0) begin nerr++; $display("FAIL ret_t0 got %b want 0", vld2); end
        @(negedge clk);
        fvld = 4'b0001;
        #1;
        ncmp++; if (vld2 !== 1'b0) begin nerr++; $display("FAIL ret_t1 got %b want 0", vld2); end
        @(negedge clk);
        fvld = '0;
        #1;
        ncmp++; if (vld2 !== 1'b1 || rd_data2 !== 64'hDEAD_BEEF || byte_len2 !== 32'd1500) begin nerr++; $display("FAIL ret_t2 got vld=%b d=%h l=%0d want 1/deadbeef/1500", vld2, rd_data2, byte_len2); end
        @(negedge clk);
        #1;
        ncmp++; if (vld2 !== 1'b0) begin nerr++; $display("FAIL ret_t3 got %b want 0", vld2); end
        done = 1'b1;
        @(negedge clk); done = 1'b0;
    endtask

    task automatic test_async_reset();
        reset_dut();
        @(negedge clk);
        core_en = 4'hF; rfd = 4'b0010; ack = 1'b1;
        @(negedge clk);
        ack = 1'b0; rfd = 4'hF; fdata[127:64] = 64'hDEAD_BEEF; fvld = 4'b0010;
        @(negedge clk);
        @(negedge clk);
        #1;
        ncmp++; if (vld0 !== 1'b1 || vld2 !== 1'b1) begin nerr++; $display("FAIL ar_pre got %b/%b want 1/1", vld0, vld2); end
        #2;
        rst = 1'b0; ack = 1'b1;
        #1;
        ncmp++; if (busy0 !== 1'b0 || busy2 !== 1'b0) begin nerr++; $display("FAIL ar_busy got %b/%b want 0/0", busy0, busy2); end
        ncmp++; if (rdy0 !== 1'b0 || ack0 !== 4'b0000) begin nerr++; $display("FAIL ar_rdy got rdy=%b ack=%b want 0/0000", rdy0, ack0); end
        ncmp++; if (vld0 !== 1'b0 || vld2 !== 1'b0 || rd_data2 !== 64'd0) begin nerr++; $display("FAIL ar_vld got %b/%b d=%h want 0/0/0", vld0, vld2, rd_data2); end
        @(negedge clk);
        rst = 1'b1; fvld = '0;
        #1;
        ncmp++; if (ack0 !== 4'b0001 || rdy0 !== 1'b1) begin nerr++; $display("FAIL ar_first got ack=%b rdy=%b want 0001/1", ack0, rdy0); end
        @(negedge clk); ack = 1'b0; done = 1'b1;
        @(negedge clk); done = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_first_grant();
        test_rotation();
        test_mask();
        test_core3();
        test_return_path();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end
endmodule
